// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage request, status and data-memory port bundle.
// master = pipeline/memory side, slave = the store buffer itself.
interface store_buffer_if #(
   parameter int DEPTH = 4
);
   logic                     st_valid;
   logic                     st_ready;
   logic [31:0]              st_addr;
   logic [31:0]              st_data;
   logic [2:0]               st_type;
   logic                     ld_req;
   logic [31:0]              ld_addr;
   logic [2:0]               ld_type;
   logic                     ld_stall;
   logic                     drained;
   logic [$clog2(DEPTH):0]   count;
   logic                     misalign_err;
   logic                     dm_MemWrite;
   logic                     dm_MemRead;
   logic [2:0]               dm_DMType;
   logic [31:0]              dm_Address;
   logic [31:0]              dm_Write_data;

   modport master (
      output st_valid, st_addr, st_data, st_type,
      output ld_req, ld_addr, ld_type,
      input  st_ready, ld_stall, drained, count,
      input  misalign_err,
      input  dm_MemWrite, dm_MemRead, dm_DMType,
      input  dm_Address, dm_Write_data
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_type,
      input  ld_req, ld_addr, ld_type,
      output st_ready, ld_stall, drained, count,
      output misalign_err,
      output dm_MemWrite, dm_MemRead, dm_DMType,
      output dm_Address, dm_Write_data
   );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between the MEM stage and data memory.
// Define SB_MISALIGN_CHECK_EN to trap misaligned loads/stores.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rstn,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  typ;
   } sb_entry_t;

   typedef struct packed {
      logic [29:0] lo;
      logic [29:0] hi;
   } fp_t;

   sb_entry_t     fifo_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;

   logic      full;
   logic      empty;
   logic      push;
   logic      pop;
   logic      st_ok;
   logic      conflict;
   logic      ld_issue;
   sb_entry_t head_e;
   fp_t       ld_fp;

   // Words touched by an access; the last byte may spill into the next word.
   function automatic fp_t footprint(
      input logic [31:0] a,
      input logic [1:0]  sz
   );
      logic [31:0] last;
      fp_t         f;
      unique case (sz)
         2'b00:   last = a;
         2'b01:   last = a + 32'd1;
         default: last = a + 32'd3;
      endcase
      f.lo = a[31:2];
      f.hi = last[31:2];
      return f;
   endfunction

   function automatic logic overlap(
      input fp_t a,
      input fp_t b
   );
      return (a.lo == b.lo) || (a.lo == b.hi) ||
             (a.hi == b.lo) || (a.hi == b.hi);
   endfunction

   function automatic logic live(
      input logic [PW-1:0] idx,
      input logic [PW-1:0] head,
      input logic [CW-1:0] cnt
   );
      logic [PW-1:0] rel;
      rel = idx - head;
      return {1'b0, rel} < cnt;
   endfunction

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign head_e = fifo_q[head_q];
   assign ld_fp  = footprint(sb.ld_addr, sb.ld_type[1:0]);

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live(PW'(i), head_q, count_q) &&
             overlap(ld_fp,
                     footprint(fifo_q[i].addr,
                               fifo_q[i].typ[1:0])))
            conflict = 1'b1;
      end
      conflict = conflict & sb.ld_req;
   end

`ifdef SB_MISALIGN_CHECK_EN
   function automatic logic misaligned(
      input logic [1:0] a,
      input logic [1:0] sz
   );
      return ((sz == 2'b01) && a[0]) ||
             (sz[1] && (a != 2'b00));
   endfunction

   logic st_mis;
   logic ld_mis;
   logic mis_q;

   assign st_mis = misaligned(sb.st_addr[1:0], sb.st_type[1:0]);
   assign ld_mis = misaligned(sb.ld_addr[1:0], sb.ld_type[1:0]);
   assign st_ok  = !st_mis;

   // A misaligned store is consumed but dropped; loads still issue.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= (sb.st_valid && !full && st_mis) ||
                  (ld_issue && ld_mis);
      end
   end

   assign sb.misalign_err = mis_q;
`else
   assign st_ok           = 1'b1;
   assign sb.misalign_err = 1'b0;
`endif

   assign sb.st_ready = !full;
   assign sb.drained  = empty;
   assign sb.count    = count_q;
   assign sb.ld_stall = sb.ld_req && (conflict || full);

   // Loads own the port; the head drains only when no load issues.
   assign ld_issue = rstn && sb.ld_req && !sb.ld_stall;
   assign pop      = !ld_issue && !empty;
   assign push     = sb.st_valid && !full && st_ok;

   always_comb begin
      sb.dm_MemWrite   = 1'b0;
      sb.dm_MemRead    = 1'b0;
      sb.dm_DMType     = 3'b000;
      sb.dm_Address    = 32'h0;
      sb.dm_Write_data = 32'h0;
      if (ld_issue) begin
         sb.dm_MemRead = 1'b1;
         sb.dm_DMType  = sb.ld_type;
         sb.dm_Address = sb.ld_addr;
      end else if (pop) begin
         sb.dm_MemWrite   = 1'b1;
         sb.dm_DMType     = head_e.typ;
         sb.dm_Address    = head_e.addr;
         sb.dm_Write_data = head_e.data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            fifo_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_q[tail_q] <= '{addr: sb.st_addr,
                                data: sb.st_data,
                                typ:  sb.st_type};
            tail_q <= tail_q + 1'b1;
         end
         if (pop)
            head_q <= head_q + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
      end
   end
endmodule
